// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//
// Purpose: shares a single cache command port between two masters (m0, m1).
// One transaction is in flight at a time.  In IDLE a request is granted
// round-robin: a lone valid port always wins, and on a tie the port that was
// not granted last wins.  The granted command is registered onto the c_*
// outputs and held through ISSUE until the cache takes it (c_stall=0).
// Reads then wait in RESP for the data, which is delivered to the owning
// master with a one-cycle rvalid pulse.
//
// Optional feature macro: CACHE_ARB_FLUSH_EN
//   When defined, flush_req/flush_ack ports exist.  A flush request has
//   absolute priority in IDLE.  It issues a write of 0 to FLUSH_ADDR and
//   pulses flush_ack once the cache stops stalling after acceptance.  The
//   round-robin pointer is left untouched.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   m0_*/m1_* (inputs)       valid, we (1=write), addr[W_A], d[W_D]
//   m0_*/m1_* (outputs)      ready (capture pulse), rdata[W_D], rvalid (pulse)
//   c_addr, c_we, c_re, c_d  registered cache command
//   c_q, c_stall             cache read data and stall
//   flush_req, flush_ack     flush handshake (CACHE_ARB_FLUSH_EN only)
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
  parameter int W_D = 32,
  parameter int W_A = 27,
  parameter logic [W_A-1:0] FLUSH_ADDR = 'h10
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           m0_valid,
  input  logic           m0_we,
  input  logic [W_A-1:0] m0_addr,
  input  logic [W_D-1:0] m0_d,
  output logic           m0_ready,
  output logic [W_D-1:0] m0_rdata,
  output logic           m0_rvalid,
  input  logic           m1_valid,
  input  logic           m1_we,
  input  logic [W_A-1:0] m1_addr,
  input  logic [W_D-1:0] m1_d,
  output logic           m1_ready,
  output logic [W_D-1:0] m1_rdata,
  output logic           m1_rvalid,
  output logic [W_A-1:0] c_addr,
  output logic           c_we,
  output logic           c_re,
  output logic [W_D-1:0] c_d,
  input  logic [W_D-1:0] c_q,
  input  logic           c_stall
`ifdef CACHE_ARB_FLUSH_EN
  ,
  input  logic           flush_req,
  output logic           flush_ack
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t         r_state, w_nState;
  logic           r_owner, w_nOwner;
  logic           r_last, w_nLast;
  logic           r_isFlush, w_nIsFlush;
  logic [W_A-1:0] r_cAddr, w_nAddr;
  logic           r_cWe, w_nWe;
  logic           r_cRe, w_nRe;
  logic [W_D-1:0] r_cD, w_nD;
  logic           r_ready0, w_nReady0;
  logic           r_ready1, w_nReady1;
  logic           r_rvalid0, w_nRvalid0;
  logic           r_rvalid1, w_nRvalid1;
  logic [W_D-1:0] r_rdata0, w_nRdata0;
  logic [W_D-1:0] r_rdata1, w_nRdata1;
  logic           w_flushReq;
  logic           w_pick1;
`ifdef CACHE_ARB_FLUSH_EN
  logic           r_flushAck, w_nFlushAck;
  assign w_flushReq = flush_req;
  assign flush_ack  = r_flushAck;
`else
  assign w_flushReq = 1'b0;
`endif

  // r_last==1 means m1 was granted last, so m0 wins a tie.
  assign w_pick1 = m1_valid && (!m0_valid || !r_last);

  assign c_addr    = r_cAddr;
  assign c_we      = r_cWe;
  assign c_re      = r_cRe;
  assign c_d       = r_cD;
  assign m0_ready  = r_ready0;
  assign m1_ready  = r_ready1;
  assign m0_rvalid = r_rvalid0;
  assign m1_rvalid = r_rvalid1;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;

  // State and registered outputs.  Reset abandons any transaction in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_isFlush <= 1'b0;
      r_cAddr   <= '0;
      r_cWe     <= 1'b0;
      r_cRe     <= 1'b0;
      r_cD      <= '0;
      r_ready0  <= 1'b0;
      r_ready1  <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
`ifdef CACHE_ARB_FLUSH_EN
      r_flushAck <= 1'b0;
`endif
    end else begin
      r_state   <= w_nState;
      r_owner   <= w_nOwner;
      r_last    <= w_nLast;
      r_isFlush <= w_nIsFlush;
      r_cAddr   <= w_nAddr;
      r_cWe     <= w_nWe;
      r_cRe     <= w_nRe;
      r_cD      <= w_nD;
      r_ready0  <= w_nReady0;
      r_ready1  <= w_nReady1;
      r_rvalid0 <= w_nRvalid0;
      r_rvalid1 <= w_nRvalid1;
      r_rdata0  <= w_nRdata0;
      r_rdata1  <= w_nRdata1;
`ifdef CACHE_ARB_FLUSH_EN
      r_flushAck <= w_nFlushAck;
`endif
    end
  end

  // Next state and next register values.  Pulses default low; everything
  // else holds, which keeps c_* stable through ISSUE and rdata sticky.
  always_comb begin
    w_nState   = r_state;
    w_nOwner   = r_owner;
    w_nLast    = r_last;
    w_nIsFlush = r_isFlush;
    w_nAddr    = r_cAddr;
    w_nWe      = r_cWe;
    w_nRe      = r_cRe;
    w_nD       = r_cD;
    w_nReady0  = 1'b0;
    w_nReady1  = 1'b0;
    w_nRvalid0 = 1'b0;
    w_nRvalid1 = 1'b0;
    w_nRdata0  = r_rdata0;
    w_nRdata1  = r_rdata1;
`ifdef CACHE_ARB_FLUSH_EN
    w_nFlushAck = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (w_flushReq) begin
          w_nIsFlush = 1'b1;
          w_nAddr    = FLUSH_ADDR;
          w_nWe      = 1'b1;
          w_nRe      = 1'b0;
          w_nD       = '0;
          w_nState   = ISSUE;
        end else if (m0_valid || m1_valid) begin
          w_nIsFlush = 1'b0;
          w_nOwner   = w_pick1;
          w_nLast    = w_pick1;
          w_nAddr    = w_pick1 ? m1_addr : m0_addr;
          w_nWe      = w_pick1 ? m1_we : m0_we;
          w_nRe      = w_pick1 ? !m1_we : !m0_we;
          w_nD       = w_pick1 ? m1_d : m0_d;
          w_nReady0  = !w_pick1;
          w_nReady1  = w_pick1;
          w_nState   = ISSUE;
        end
      end
      ISSUE: begin
        if (!c_stall) begin
          w_nWe = 1'b0;
          w_nRe = 1'b0;
          // A flush also waits in RESP: the cache stalls until it is done.
          w_nState = (r_cRe || r_isFlush) ? RESP : IDLE;
        end
      end
      RESP: begin
        if (!c_stall) begin
          w_nState = IDLE;
          if (r_isFlush) begin
`ifdef CACHE_ARB_FLUSH_EN
            w_nFlushAck = 1'b1;
`endif
          end else if (r_owner) begin
            w_nRdata1  = c_q;
            w_nRvalid1 = 1'b1;
          end else begin
            w_nRdata0  = c_q;
            w_nRvalid0 = 1'b1;
          end
        end
      end
      default: w_nState = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
//
// Directed bench for cache_port_arbiter.  Inputs are driven and outputs are
// sampled 1 time unit after each rising clock edge.  Flush behaviour is
// exercised only when CACHE_ARB_FLUSH_EN is defined; otherwise a master write
// to the flush address is checked to pass through unchanged.
// ---------------------------------------------------------------------------
module tb_cache_port_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        m0_valid, m0_we, m1_valid, m1_we;
  logic [26:0] m0_addr, m1_addr;
  logic [31:0] m0_d, m1_d;
  logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [26:0] c_addr;
  logic        c_we, c_re;
  logic [31:0] c_d, c_q;
  logic        c_stall;
`ifdef CACHE_ARB_FLUSH_EN
  logic        flush_req;
  logic        flush_ack;
`endif

  int nCompared = 0;
  int nFailed   = 0;

  cache_port_arbiter dut (
    .CLK(CLK), .RST(RST),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_d(m0_d),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_d(m1_d),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .c_addr(c_addr), .c_we(c_we), .c_re(c_re), .c_d(c_d),
    .c_q(c_q), .c_stall(c_stall)
`ifdef CACHE_ARB_FLUSH_EN
    , .flush_req(flush_req), .flush_ack(flush_ack)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic we0, input logic [26:0] a0,
                               input logic [31:0] d0, input logic v1, input logic we1,
                               input logic [26:0] a1, input logic [31:0] d1);
    m0_valid = v0; m0_we = we0; m0_addr = a0; m0_d = d0;
    m1_valid = v1; m1_we = we1; m1_addr = a1; m1_d = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nFailed++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    c_q = '0;
    c_stall = 1'b0;
`ifdef CACHE_ARB_FLUSH_EN
    flush_req = 1'b0;
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Reset values
    checkOutput("rst_c_re", c_re, 0);
    checkOutput("rst_c_we", c_we, 0);
    checkOutput("rst_c_addr", c_addr, 0);
    checkOutput("rst_c_d", c_d, 0);
    checkOutput("rst_m0_ready", m0_ready, 0);
    checkOutput("rst_m1_rvalid", m1_rvalid, 0);
    checkOutput("rst_m0_rdata", m0_rdata, 0);
    RST = 1'b0;
    tick();

    // Simple read: ready at T, c_re one cycle, rvalid at T+2
    c_q = 32'hDEADBEEF;
    applyStimulus(1, 0, 27'h100, 0, 0, 0, 0, 0);
    tick();
    checkOutput("rd_m0_ready", m0_ready, 1);
    checkOutput("rd_m1_ready", m1_ready, 0);
    checkOutput("rd_c_re", c_re, 1);
    checkOutput("rd_c_we", c_we, 0);
    checkOutput("rd_c_addr", c_addr, 27'h100);
    m0_valid = 1'b0;
    tick();
    checkOutput("rd_c_re_drop", c_re, 0);
    checkOutput("rd_ready_drop", m0_ready, 0);
    checkOutput("rd_rvalid_early", m0_rvalid, 0);
    tick();
    checkOutput("rd_rvalid", m0_rvalid, 1);
    checkOutput("rd_rdata", m0_rdata, 32'hDEADBEEF);
    checkOutput("rd_m1_rvalid", m1_rvalid, 0);
    c_q = 32'h0;
    tick();
    checkOutput("rd_rvalid_pulse", m0_rvalid, 0);
    checkOutput("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // Fresh reset so the first tie goes to m0, then alternate
    RST = 1'b1; tick(); RST = 1'b0;
    applyStimulus(1, 0, 27'h1A0, 0, 1, 0, 27'h2B0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("rr_m0_ready", m0_ready, (i % 2 == 0));
      checkOutput("rr_m1_ready", m1_ready, (i % 2 == 1));
      checkOutput("rr_c_addr", c_addr, (i % 2 == 0) ? 27'h1A0 : 27'h2B0);
      c_q = 32'hC0DE0000 + i;
      tick();
      checkOutput("rr_c_re_clear", c_re, 0);
      tick();
      checkOutput("rr_m0_rvalid", m0_rvalid, (i % 2 == 0));
      checkOutput("rr_m1_rvalid", m1_rvalid, (i % 2 == 1));
      if (i % 2 == 0) checkOutput("rr_m0_rdata", m0_rdata, 32'hC0DE0000 + i);
      else begin
        checkOutput("rr_m1_rdata", m1_rdata, 32'hC0DE0000 + i);
        checkOutput("rr_m0_rdata_hold", m0_rdata, 32'hC0DE0000 + i - 1);
      end
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Read miss: stall 10 cycles in RESP
    applyStimulus(1, 0, 27'h300, 0, 0, 0, 0, 0);
    tick();
    checkOutput("miss_ready", m0_ready, 1);
    m0_valid = 1'b0;
    tick();
    c_stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("miss_rvalid", m0_rvalid, 0);
      checkOutput("miss_c_re", c_re, 0);
      checkOutput("miss_c_addr", c_addr, 27'h300);
    end
    c_stall = 1'b0;
    c_q = 32'h12345678;
    tick();
    checkOutput("miss_rvalid_end", m0_rvalid, 1);
    checkOutput("miss_rdata", m0_rdata, 32'h12345678);

    // m1 write with 3 stall cycles at issue
    applyStimulus(0, 0, 0, 0, 1, 1, 27'h200, 32'h55);
    c_stall = 1'b1;
    tick();
    checkOutput("wr_m1_ready", m1_ready, 1);
    checkOutput("wr_c_we", c_we, 1);
    checkOutput("wr_c_re", c_re, 0);
    checkOutput("wr_c_addr", c_addr, 27'h200);
    checkOutput("wr_c_d", c_d, 32'h55);
    m1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("wr_c_we_held", c_we, 1);
      checkOutput("wr_c_d_held", c_d, 32'h55);
    end
    c_stall = 1'b0;
    tick();
    checkOutput("wr_c_we_clear", c_we, 0);
    checkOutput("wr_no_rvalid1", m1_rvalid, 0);
    tick();
    checkOutput("wr_no_rvalid1_b", m1_rvalid, 0);
    checkOutput("wr_no_rvalid0", m0_rvalid, 0);

    // Reset in RESP after an m0 grant; next tie must go to m0
    applyStimulus(1, 0, 27'h400, 0, 0, 0, 0, 0);
    c_q = 32'hA5A5A5A5;
    tick();
    checkOutput("rstresp_ready", m0_ready, 1);
    m0_valid = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    checkOutput("rstresp_rvalid0", m0_rvalid, 0);
    checkOutput("rstresp_rvalid1", m1_rvalid, 0);
    checkOutput("rstresp_c_addr", c_addr, 0);
    checkOutput("rstresp_rdata0", m0_rdata, 0);
    checkOutput("rstresp_rdata1", m1_rdata, 0);
    RST = 1'b0;
    tick();
    checkOutput("rstresp_rvalid_after", m0_rvalid, 0);
    applyStimulus(1, 0, 27'h1A0, 0, 1, 0, 27'h2B0, 0);
    tick();
    checkOutput("rstresp_tie_m0", m0_ready, 1);
    checkOutput("rstresp_tie_m1", m1_ready, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick(); tick();

`ifdef CACHE_ARB_FLUSH_EN
    // Flush beats a simultaneous m0 request; m0 is granted afterwards
    flush_req = 1'b1;
    applyStimulus(1, 0, 27'h500, 0, 0, 0, 0, 0);
    tick();
    checkOutput("fl_c_we", c_we, 1);
    checkOutput("fl_c_addr", c_addr, 27'h10);
    checkOutput("fl_c_d", c_d, 0);
    checkOutput("fl_m0_ready", m0_ready, 0);
    flush_req = 1'b0;
    tick();
    checkOutput("fl_c_we_clear", c_we, 0);
    c_stall = 1'b1;
    tick(); tick();
    checkOutput("fl_ack_early", flush_ack, 0);
    c_stall = 1'b0;
    tick();
    checkOutput("fl_ack", flush_ack, 1);
    checkOutput("fl_m0_ready_wait", m0_ready, 0);
    tick();
    checkOutput("fl_m0_granted", m0_ready, 1);
    checkOutput("fl_m0_addr", c_addr, 27'h500);
    checkOutput("fl_ack_pulse", flush_ack, 0);
    m0_valid = 1'b0;
    tick(); tick();
`else
    // Without the flush feature a write to the flush address is ordinary
    applyStimulus(1, 1, 27'h10, 32'hAB, 0, 0, 0, 0);
    tick();
    checkOutput("fa_c_addr", c_addr, 27'h10);
    checkOutput("fa_c_d", c_d, 32'hAB);
    checkOutput("fa_c_we", c_we, 1);
    checkOutput("fa_m0_ready", m0_ready, 1);
    m0_valid = 1'b0;
    tick(); tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
    $finish;
  end

endmodule
